// File: rtl/vga_sincronismo.sv
// vga_sincronismo: 640x480@60Hz VGA timing generator.
// A clock divider produces pixel_tick, which advances the coluna/linha raster
// counters. areaAtiva, hsync and vsync are registered from the next counter
// values, so they always line up with the coluna/linha being presented.
// A run state machine (RODANDO/PARANDO/PARADO) lets habilita park the raster
// at (0,0) once the current frame has finished.
// Optional feature macro: VGA_CONTADOR_QUADRO_EN enables the 16-bit frame
// counter; without it contador_quadro is tied to zero.
module vga_sincronismo #(
  parameter int DIV      = 2,
  parameter int H_ATIVO  = 640,
  parameter int H_FRENTE = 16,
  parameter int H_SYNC   = 96,
  parameter int H_TRAS   = 48,
  parameter int V_ATIVO  = 480,
  parameter int V_FRENTE = 10,
  parameter int V_SYNC   = 2,
  parameter int V_TRAS   = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        habilita,
  output logic        pixel_tick,
  output logic [9:0]  coluna,
  output logic [9:0]  linha,
  output logic        areaAtiva,
  output logic        hsync,
  output logic        vsync,
  output logic        fim_quadro,
  output logic [15:0] contador_quadro
);

  localparam int H_TOTAL = H_ATIVO + H_FRENTE + H_SYNC + H_TRAS;
  localparam int V_TOTAL = V_ATIVO + V_FRENTE + V_SYNC + V_TRAS;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
  localparam logic [9:0] H_MAX  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ATV  = 10'(H_ATIVO);
  localparam logic [9:0] V_ATV  = 10'(V_ATIVO);
  localparam logic [9:0] H_SINI = 10'(H_ATIVO + H_FRENTE);
  localparam logic [9:0] H_SFIM = 10'(H_ATIVO + H_FRENTE + H_SYNC - 1);
  localparam logic [9:0] V_SINI = 10'(V_ATIVO + V_FRENTE);
  localparam logic [9:0] V_SFIM = 10'(V_ATIVO + V_FRENTE + V_SYNC - 1);
  localparam logic SYNC_ON  = SYNC_POL;
  localparam logic SYNC_OFF = ~SYNC_POL;

  typedef enum logic [1:0] {
    RODANDO = 2'd0,
    PARANDO = 2'd1,
    PARADO  = 2'd2
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [DW-1:0] div_q, div_d;
  logic          tick_q, tick_d;
  logic [9:0]    coluna_q, coluna_d;
  logic [9:0]    linha_q, linha_d;
  logic          area_q, area_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          fim_q, fim_d;
  logic          avanca_s, wrap_s, parado_s;

  // Divider: count 0..DIV-1; the tick is registered so it is high while div_q==DIV-1.
  always_comb begin
    div_d  = div_q;
    tick_d = 1'b0;
    if (div_q == DIV_MAX) begin
      div_d = '0;
    end else begin
      div_d = div_q + DW'(1);
    end
    tick_d = (div_d == DIV_MAX);
  end

  // Raster counters: advance on each pixel tick unless parked.
  always_comb begin
    avanca_s = tick_q && (estado_q != PARADO);
    wrap_s   = avanca_s && (coluna_q == H_MAX) && (linha_q == V_MAX);
    coluna_d = coluna_q;
    linha_d  = linha_q;
    if (avanca_s) begin
      if (coluna_q == H_MAX) begin
        coluna_d = 10'd0;
        if (linha_q == V_MAX) begin
          linha_d = 10'd0;
        end else begin
          linha_d = linha_q + 10'd1;
        end
      end else begin
        coluna_d = coluna_q + 10'd1;
      end
    end else begin
      coluna_d = coluna_q;
    end
  end

  // Run state machine: a stop request only takes effect at the frame wrap.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      RODANDO: begin
        if (!habilita) estado_d = PARANDO;
        else           estado_d = RODANDO;
      end
      PARANDO: begin
        if (habilita)    estado_d = RODANDO;
        else if (wrap_s) estado_d = PARADO;
        else             estado_d = PARANDO;
      end
      PARADO: begin
        if (habilita) estado_d = RODANDO;
        else          estado_d = PARADO;
      end
      default: estado_d = RODANDO;
    endcase
  end

  // Decoded outputs computed from the next counter values for zero relative latency.
  always_comb begin
    parado_s = (estado_d == PARADO);
    area_d   = area_q;
    if (parado_s) begin
      area_d = 1'b0;
    end else if (avanca_s) begin
      area_d = (coluna_d < H_ATV) && (linha_d < V_ATV);
    end else begin
      area_d = area_q;
    end
    hsync_d = (!parado_s && (coluna_d >= H_SINI) && (coluna_d <= H_SFIM)) ? SYNC_ON : SYNC_OFF;
    vsync_d = (!parado_s && (linha_d >= V_SINI) && (linha_d <= V_SFIM)) ? SYNC_ON : SYNC_OFF;
    fim_d   = wrap_s;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= RODANDO;
      div_q    <= '0;
      tick_q   <= 1'b0;
      coluna_q <= 10'd0;
      linha_q  <= 10'd0;
      area_q   <= 1'b0;
      hsync_q  <= SYNC_OFF;
      vsync_q  <= SYNC_OFF;
      fim_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      div_q    <= div_d;
      tick_q   <= tick_d;
      coluna_q <= coluna_d;
      linha_q  <= linha_d;
      area_q   <= area_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      fim_q    <= fim_d;
    end
  end

`ifdef VGA_CONTADOR_QUADRO_EN
  logic [15:0] quadros_q;

  // Frame counter: bumps together with the fim_quadro pulse, wrapping at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quadros_q <= 16'd0;
    end else if (fim_d) begin
      quadros_q <= quadros_q + 16'd1;
    end else begin
      quadros_q <= quadros_q;
    end
  end

  assign contador_quadro = quadros_q;
`else
  assign contador_quadro = 16'd0;
`endif

  assign pixel_tick = tick_q;
  assign coluna     = coluna_q;
  assign linha      = linha_q;
  assign areaAtiva  = area_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign fim_quadro = fim_q;

endmodule

// File: tb/tb_vga_sincronismo.sv
// Testbench for vga_sincronismo using a reduced raster geometry so that
// several complete frames fit in a short run. A raster-position reference
// model (position within the frame, split into column/line arithmetically)
// predicts every output each clock; habilita is driven randomly.
module tb_vga_sincronismo;

  localparam int DIV = 2;
  localparam int HA = 20, HF = 4, HS = 6, HB = 5;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int TOTAL = HT * VT;
  localparam bit POL = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        habilita = 1'b0;
  logic        pixel_tick, areaAtiva, hsync, vsync, fim_quadro;
  logic [9:0]  coluna, linha;
  logic [15:0] contador_quadro;

  vga_sincronismo #(
    .DIV(DIV), .H_ATIVO(HA), .H_FRENTE(HF), .H_SYNC(HS), .H_TRAS(HB),
    .V_ATIVO(VA), .V_FRENTE(VF), .V_SYNC(VS), .V_TRAS(VB), .SYNC_POL(POL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .habilita(habilita), .pixel_tick(pixel_tick),
    .coluna(coluna), .linha(linha), .areaAtiva(areaAtiva), .hsync(hsync),
    .vsync(vsync), .fim_quadro(fim_quadro), .contador_quadro(contador_quadro)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // reference model state
  int m_div, m_pos, m_frames;
  bit m_tick, m_valid, m_parked, m_stop, m_fim;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_div = 0; m_pos = 0; m_frames = 0;
    m_tick = 0; m_valid = 0; m_parked = 0; m_stop = 0; m_fim = 0;
  endtask

  // One clock edge of the reference: h is the habilita value seen at that edge.
  task automatic model_edge(input bit h);
    bit t;
    t = m_tick;
    m_div = (m_div + 1) % DIV;
    m_tick = (m_div == DIV - 1);
    m_fim = 0;
    if (m_parked) begin
      if (h) m_parked = 0;
    end else if (t) begin
      m_pos = (m_pos + 1) % TOTAL;
      m_valid = 1;
      if (m_pos == 0) begin
        m_fim = 1;
        m_frames = (m_frames + 1) % 65536;
        if (m_stop && !h) begin
          m_parked = 1;
          m_valid = 0;
        end
      end
    end
    m_stop = m_parked ? 1'b0 : !h;
  endtask

  task automatic compare_all();
    int c, l;
    bit ea, eh, ev;
    c = m_pos % HT;
    l = m_pos / HT;
    ea = m_valid && (c < HA) && (l < VA);
    eh = (c >= HA + HF && c < HA + HF + HS) ? POL : !POL;
    ev = (l >= VA + VF && l < VA + VF + VS) ? POL : !POL;
    check_eq("pixel_tick", 32'(pixel_tick), 32'(m_tick));
    check_eq("coluna", 32'(coluna), 32'(c));
    check_eq("linha", 32'(linha), 32'(l));
    check_eq("areaAtiva", 32'(areaAtiva), 32'(ea));
    check_eq("hsync", 32'(hsync), 32'(eh));
    check_eq("vsync", 32'(vsync), 32'(ev));
    check_eq("fim_quadro", 32'(fim_quadro), 32'(m_fim));
`ifdef VGA_CONTADOR_QUADRO_EN
    check_eq("contador_quadro", 32'(contador_quadro), 32'(m_frames));
`else
    check_eq("contador_quadro", 32'(contador_quadro), 32'd0);
`endif
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_tick"}, 32'(pixel_tick), 32'd0);
    check_eq({tag, "_coluna"}, 32'(coluna), 32'd0);
    check_eq({tag, "_linha"}, 32'(linha), 32'd0);
    check_eq({tag, "_area"}, 32'(areaAtiva), 32'd0);
    check_eq({tag, "_hsync"}, 32'(hsync), 32'(!POL));
    check_eq({tag, "_vsync"}, 32'(vsync), 32'(!POL));
    check_eq({tag, "_fim"}, 32'(fim_quadro), 32'd0);
    check_eq({tag, "_quadro"}, 32'(contador_quadro), 32'd0);
  endtask

  // Drive habilita for the next edge, advance the model, then check at negedge.
  task automatic cycle(input bit h);
    habilita = h;
    model_edge(h);
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  initial begin
    bit h, found;
    int nf, last, stop_at;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    habilita = 1'b1;

    // Two uninterrupted frames; also measure the frame length between pulses.
    nf = 0; last = 0;
    for (int i = 0; i < 2 * TOTAL * DIV + 20; i++) begin
      cycle(1'b1);
      if (fim_quadro) begin
        if (nf > 0) check_eq("frame_len", 32'(cyc - last), 32'(TOTAL * DIV));
        nf++;
        last = cyc;
      end
    end
    check_eq("frames_seen", 32'(nf), 32'd2);

    // Directed stop: drop habilita mid-frame, let the frame finish and park.
    found = 0;
    for (int i = 0; i < 2 * TOTAL * DIV && !found; i++) begin
      cycle(1'b1);
      if (linha == 10'd6) found = 1;
    end
    check_eq("reach_lin6", 32'(found), 32'd1);
    for (int i = 0; i < TOTAL * DIV + 300; i++) cycle(1'b0);
    check_eq("parked_coluna", 32'(coluna), 32'd0);
    check_eq("parked_linha", 32'(linha), 32'd0);
    check_eq("parked_area", 32'(areaAtiva), 32'd0);
    for (int i = 0; i < 200; i++) cycle(1'b1);

    // Random habilita activity with long runs.
    h = 1'b1;
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 399) == 0) h = ~h;
      cycle(h);
    end

    // Asynchronous reset at a random mid-frame point.
    stop_at = $urandom_range(100, TOTAL * DIV - 100);
    for (int i = 0; i < stop_at; i++) cycle(1'b1);
    #1 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("rst_hold");
    rst_n = 1'b1;

    // Three full frames after reset; frame counter must match the build option.
    nf = 0; last = 0;
    for (int i = 0; i < 3 * TOTAL * DIV + 50 && nf < 3; i++) begin
      cycle(1'b1);
      if (fim_quadro) begin
        if (nf > 0) check_eq("frame_len2", 32'(cyc - last), 32'(TOTAL * DIV));
        nf++;
        last = cyc;
      end
    end
    check_eq("frames_after_rst", 32'(nf), 32'd3);
`ifdef VGA_CONTADOR_QUADRO_EN
    check_eq("contador_3", 32'(contador_quadro), 32'd3);
`else
    check_eq("contador_off", 32'(contador_quadro), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
